// File: rtl/text_console_pipe_if.sv
// ---------------------------------------------------------------------------
// text_console_pipe_if
// Memory-side bus of the text console renderer: character fetch from video
// RAM and glyph-row fetch from font ROM. Both memories are synchronous with
// a single cycle of read latency.
//   vram_addr  : character cell address (renderer -> VRAM)
//   vram_data  : character code, valid the cycle after vram_addr
//   font_addr  : {char, glyph_row} (renderer -> font ROM)
//   font_data  : glyph row bits, MSB = leftmost pixel
// Modports: master = renderer, slave = memories.
// ---------------------------------------------------------------------------
interface text_console_pipe_if #(
    parameter int ADDR_W       = 12,
    parameter int GLYPH_W_LOG2 = 3,
    parameter int GLYPH_H_LOG2 = 4
);
    logic [ADDR_W-1:0]              vram_addr;
    logic [7:0]                     vram_data;
    logic [8+GLYPH_H_LOG2-1:0]      font_addr;
    logic [(1<<GLYPH_W_LOG2)-1:0]   font_data;

    modport master (
        output vram_addr,
        output font_addr,
        input  vram_data,
        input  font_data
    );

    modport slave (
        input  vram_addr,
        input  font_addr,
        output vram_data,
        output font_data
    );
endinterface

// File: rtl/text_console_pipe.sv
// ---------------------------------------------------------------------------
// text_console_pipe
// Text-mode renderer stage on the 26-bit pixel stream
// ({RGB[2:0], XC[9:0], YC[9:0], HS, VS, Active}). Each pixel is mapped to a
// character cell, the character code is fetched from VRAM, the glyph row is
// fetched from font ROM, and the pixel is recoloured fg/bg. Supports a
// hardware vertical scroll (latched at VS rise) and a blinking block cursor.
// Fixed latency of 4 cycles, no stalls.
//   px_clk, reset : pixel clock, synchronous active-high reset
//   RGBStr_i/o    : input / output pixel stream
//   mem           : VRAM and font ROM bus (master side)
//   scroll_row    : physical row shown at logical row 0
//   cursor_*      : cursor position (logical) and enable
//   fg_rgb/bg_rgb : text colours, sampled at the output stage
// ---------------------------------------------------------------------------
module text_console_pipe #(
    parameter int GLYPH_W_LOG2 = 3,
    parameter int GLYPH_H_LOG2 = 4,
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int ADDR_W       = 12,
    parameter int BLINK_FRAMES = 32,
    localparam int ROW_W       = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int COL_W       = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                 px_clk,
    input  logic                 reset,
    input  logic [25:0]          RGBStr_i,
    output logic [25:0]          RGBStr_o,
    text_console_pipe_if.master  mem,
    input  logic [ROW_W-1:0]     scroll_row,
    input  logic [COL_W-1:0]     cursor_col,
    input  logic [ROW_W-1:0]     cursor_row,
    input  logic                 cursor_en,
    input  logic [2:0]           fg_rgb,
    input  logic [2:0]           bg_rgb
);
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [9:0]               w_col;
    logic [9:0]               w_row;
    logic [9:0]               w_phys_sum;
    logic [9:0]               w_phys;
    logic                     w_area;
    logic                     w_hit;
    logic                     w_vs_rise;
    logic [ADDR_W-1:0]        w_addr;
    logic                     w_pix;
    logic [2:0]               w_rgb;

    logic                     r_vs_prev;
    logic [ROW_W-1:0]         r_scroll_q;
    logic [FC_W-1:0]          r_frame_cnt;
    logic                     r_blink_on;

    // Stage n holds the side-band of the pixel sampled n-1 edges earlier.
    // Only [22:0] of the stream travels; RGB is regenerated at the output.
    logic [22:0]              r_str1, r_str2, r_str3, r_str4;
    logic [GLYPH_W_LOG2-1:0]  r_xoff1, r_xoff2, r_xoff3, r_xoff4;
    logic [GLYPH_H_LOG2-1:0]  r_yoff1, r_yoff2;
    logic                     r_area1, r_area2, r_area3, r_area4;
    logic                     r_hit1, r_hit2, r_hit3, r_hit4;

    always_comb begin
        w_col      = RGBStr_i[22:13] >> GLYPH_W_LOG2;
        w_row      = RGBStr_i[12:3] >> GLYPH_H_LOG2;
        w_area     = (w_col >= 10'(COLS)) || (w_row >= 10'(ROWS));
        // Scroll value is always < ROWS, so one subtract suffices.
        w_phys_sum = w_row + 10'(r_scroll_q);
        w_phys     = (w_phys_sum >= 10'(ROWS)) ? (w_phys_sum - 10'(ROWS)) : w_phys_sum;
        w_addr     = w_area ? '0 : (ADDR_W'(w_phys) * ADDR_W'(COLS) + ADDR_W'(w_col));
        // Cursor is matched on the logical row so it stays put while scrolling.
        w_hit      = cursor_en && (w_col == 10'(cursor_col)) &&
                     (w_row == 10'(cursor_row)) && !w_area;
        w_vs_rise  = RGBStr_i[1] && !r_vs_prev;
    end

    always_comb begin
        // ~xoff selects bit (glyph_width-1-xoff): MSB is the leftmost pixel.
        w_pix = mem.font_data[~r_xoff4] ^ (r_hit4 & r_blink_on);
        if (!r_str4[0]) begin
            w_rgb = 3'b000;
        end else if (r_area4) begin
            w_rgb = bg_rgb;
        end else begin
            w_rgb = w_pix ? fg_rgb : bg_rgb;
        end
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            r_vs_prev     <= 1'b0;
            r_scroll_q    <= '0;
            r_frame_cnt   <= '0;
            r_blink_on    <= 1'b1;
            mem.vram_addr <= '0;
            mem.font_addr <= '0;
            RGBStr_o      <= '0;
            r_str1  <= '0;  r_str2  <= '0;  r_str3  <= '0;  r_str4  <= '0;
            r_xoff1 <= '0;  r_xoff2 <= '0;  r_xoff3 <= '0;  r_xoff4 <= '0;
            r_yoff1 <= '0;  r_yoff2 <= '0;
            r_area1 <= 1'b0; r_area2 <= 1'b0; r_area3 <= 1'b0; r_area4 <= 1'b0;
            r_hit1  <= 1'b0; r_hit2  <= 1'b0; r_hit3  <= 1'b0; r_hit4  <= 1'b0;
        end else begin
            r_vs_prev <= RGBStr_i[1];
            if (w_vs_rise) begin
                r_scroll_q <= (32'(scroll_row) >= ROWS) ? '0 : scroll_row;
                if (32'(r_frame_cnt) == BLINK_FRAMES - 1) begin
                    r_frame_cnt <= '0;
                    r_blink_on  <= !r_blink_on;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end

            // Stage 1: cell address out to VRAM.
            mem.vram_addr <= w_addr;
            r_str1  <= RGBStr_i[22:0];
            r_xoff1 <= RGBStr_i[13 +: GLYPH_W_LOG2];
            r_yoff1 <= RGBStr_i[3 +: GLYPH_H_LOG2];
            r_area1 <= w_area;
            r_hit1  <= w_hit;

            // Stage 2: VRAM read in flight.
            r_str2  <= r_str1;
            r_xoff2 <= r_xoff1;
            r_yoff2 <= r_yoff1;
            r_area2 <= r_area1;
            r_hit2  <= r_hit1;

            // Stage 3: character code arrives, glyph row address out to ROM.
            mem.font_addr <= {mem.vram_data, r_yoff2};
            r_str3  <= r_str2;
            r_xoff3 <= r_xoff2;
            r_area3 <= r_area2;
            r_hit3  <= r_hit2;

            // Stage 4: font ROM read in flight.
            r_str4  <= r_str3;
            r_xoff4 <= r_xoff3;
            r_area4 <= r_area3;
            r_hit4  <= r_hit3;

            // Output: glyph row is valid, colour the pixel.
            RGBStr_o <= {w_rgb, r_str4};
        end
    end
endmodule

// File: tb/tb_text_console_pipe.sv
// ---------------------------------------------------------------------------
// tb_text_console_pipe
// Bench for text_console_pipe. Behavioural VRAM/font ROM models feed the DUT;
// an expected output word is pushed to a queue for every driven pixel and
// popped when that pixel leaves the 4-cycle pipe.
// ---------------------------------------------------------------------------
module tb_text_console_pipe;
    localparam logic [2:0] FG = 3'b101;
    localparam logic [2:0] BG = 3'b010;

    logic        px_clk;
    logic        reset;
    logic [25:0] RGBStr_i;
    logic [25:0] RGBStr_o;
    logic [4:0]  scroll_row;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        cursor_en;
    logic [2:0]  fg_rgb;
    logic [2:0]  bg_rgb;

    text_console_pipe_if #(.ADDR_W(12), .GLYPH_W_LOG2(3), .GLYPH_H_LOG2(4)) mem_if ();

    text_console_pipe dut (
        .px_clk     (px_clk),
        .reset      (reset),
        .RGBStr_i   (RGBStr_i),
        .RGBStr_o   (RGBStr_o),
        .mem        (mem_if),
        .scroll_row (scroll_row),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .cursor_en  (cursor_en),
        .fg_rgb     (fg_rgb),
        .bg_rgb     (bg_rgb)
    );

    logic [7:0] vram_m [0:4095];
    logic [7:0] font_m [0:4095];

    always @(posedge px_clk) begin
        mem_if.vram_data <= vram_m[mem_if.vram_addr];
        mem_if.font_data <= font_m[mem_if.font_addr];
    end

    initial px_clk = 1'b0;
    always #5 px_clk = ~px_clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [25:0] sb_q [$];
    int          m_scroll;
    int          m_fc;
    bit          m_blink;
    bit          m_vs_prev;

    function automatic logic [25:0] model_px(input logic [25:0] s);
        int col, row, xoff, yoff, phys, addr;
        bit area, hit, pix;
        logic [7:0] ch, g;
        logic [2:0] rgb;
        col  = int'(s[22:13]) / 8;
        row  = int'(s[12:3]) / 16;
        xoff = int'(s[22:13]) % 8;
        yoff = int'(s[12:3]) % 16;
        area = (col >= 80) || (row >= 30);
        phys = row + m_scroll;
        if (phys >= 30) phys = phys - 30;
        addr = area ? 0 : phys * 80 + col;
        ch   = vram_m[addr];
        g    = font_m[ch * 16 + yoff];
        hit  = cursor_en && (col == int'(cursor_col)) && (row == int'(cursor_row)) && !area;
        pix  = g[7 - xoff] ^ (hit && m_blink);
        if (!s[0])     rgb = 3'b000;
        else if (area) rgb = BG;
        else           rgb = pix ? FG : BG;
        return {rgb, s[22:0]};
    endfunction

    task automatic step(input logic [25:0] s, output logic [25:0] got,
                        output logic [25:0] exp, output bit valid);
        @(negedge px_clk);
        RGBStr_i = s;
        if (reset) begin
            sb_q.delete();
            repeat (5) sb_q.push_back('0);
            m_vs_prev = 0; m_scroll = 0; m_fc = 0; m_blink = 1;
        end else begin
            sb_q.push_back(model_px(s));
            if (s[1] && !m_vs_prev) begin
                m_scroll = (int'(scroll_row) >= 30) ? 0 : int'(scroll_row);
                if (m_fc == 31) begin m_fc = 0; m_blink = !m_blink; end
                else m_fc = m_fc + 1;
            end
            m_vs_prev = s[1];
        end
        @(posedge px_clk);
        #1;
        got = RGBStr_o;
        exp = '0;
        valid = 0;
        if (sb_q.size() >= 5) begin
            exp = sb_q.pop_front();
            valid = 1;
        end
    endtask

    task automatic vs_pulse();
        logic [25:0] g, e;
        bit v;
        step({3'b000, 10'd700, 10'd500, 3'b010}, g, e, v);
        step({3'b000, 10'd700, 10'd500, 3'b000}, g, e, v);
    endtask

    localparam logic [25:0] PX_BASIC = {3'b111, 10'd17, 10'd35, 3'b001};

    task automatic test_reset();
        logic [25:0] g, e;
        bit v;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(PX_BASIC, g, e, v);
            n_tests++;
            if (!v || g !== 26'd0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d] got=%h required=0", i, g);
            end
        end
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step(PX_BASIC, g, e, v);
            n_tests++;
            if (!v || g !== 26'd0 || e !== 26'd0) begin
                n_fail++;
                $display("FAIL reset_refill[%0d] got=%h required=0", i, g);
            end
        end
        step(PX_BASIC, g, e, v);
        n_tests++;
        if (!v || g !== {FG, PX_BASIC[22:0]}) begin
            n_fail++;
            $display("FAIL reset_first_px got=%h required=%h", g, {FG, PX_BASIC[22:0]});
        end
    endtask

    task automatic test_cell_map();
        logic [25:0] g, e;
        bit v;
        step(PX_BASIC, g, e, v);
        n_tests++;
        if (mem_if.vram_addr !== 12'd162) begin
            n_fail++;
            $display("FAIL cell_vram_addr got=%0d required=162", mem_if.vram_addr);
        end
        for (int i = 1; i <= 4; i++) begin
            step({3'b000, 10'd1, 10'd1, 3'b000}, g, e, v);
            if (i == 2) begin
                n_tests++;
                if (mem_if.font_addr !== 12'h413) begin
                    n_fail++;
                    $display("FAIL cell_font_addr got=%h required=413", mem_if.font_addr);
                end
            end
        end
        n_tests++;
        if (!v || g !== e || g !== {FG, PX_BASIC[22:0]}) begin
            n_fail++;
            $display("FAIL cell_out got=%h required=%h", g, {FG, PX_BASIC[22:0]});
        end
    endtask

    task automatic test_cursor_blink();
        logic [25:0] g, e;
        bit v;
        logic [25:0] pc, pn;
        logic [2:0]  want [4];
        pc = {3'b000, 10'd40, 10'd48, 3'b001};
        pn = {3'b000, 10'd48, 10'd48, 3'b001};
        want[0] = FG; want[1] = BG; want[2] = FG; want[3] = BG;
        cursor_col = 7'd5;
        cursor_row = 5'd3;
        cursor_en  = 1'b1;
        for (int phase = 0; phase < 4; phase++) begin
            if (phase == 1 || phase == 2) repeat (32) vs_pulse();
            if (phase == 3) cursor_en = 1'b0;
            for (int i = 0; i < 5; i++) begin
                step(pc, g, e, v);
                n_tests++;
                if (!v || g !== e) begin
                    n_fail++;
                    $display("FAIL cursor_sb[%0d.%0d] got=%h required=%h", phase, i, g, e);
                end
            end
            n_tests++;
            if (g[25:23] !== want[phase]) begin
                n_fail++;
                $display("FAIL cursor_rgb[%0d] got=%b required=%b", phase, g[25:23], want[phase]);
            end
        end
        cursor_en = 1'b1;
        for (int i = 0; i < 5; i++) step(pn, g, e, v);
        n_tests++;
        if (g !== e || g[25:23] !== BG) begin
            n_fail++;
            $display("FAIL cursor_neighbour got=%h required rgb=%b", g, BG);
        end
        cursor_en = 1'b0;
    endtask

    task automatic test_scroll();
        logic [25:0] g, e;
        bit v;
        logic [25:0] q;
        q = {3'b000, 10'd0, 10'd32, 3'b001};
        scroll_row = 5'd29;
        vs_pulse();
        step(q, g, e, v);
        n_tests++;
        if (mem_if.vram_addr !== 12'd80) begin
            n_fail++;
            $display("FAIL scroll29_addr got=%0d required=80", mem_if.vram_addr);
        end
        for (int i = 0; i < 4; i++) step(q, g, e, v);
        n_tests++;
        if (g !== e || g[25:23] !== FG) begin
            n_fail++;
            $display("FAIL scroll29_rgb got=%h required=%h", g, e);
        end
        scroll_row = 5'd31;
        vs_pulse();
        step(q, g, e, v);
        n_tests++;
        if (mem_if.vram_addr !== 12'd160) begin
            n_fail++;
            $display("FAIL scroll31_addr got=%0d required=160", mem_if.vram_addr);
        end
        for (int i = 0; i < 4; i++) step(q, g, e, v);
        n_tests++;
        if (g !== e || g[25:23] !== BG) begin
            n_fail++;
            $display("FAIL scroll31_rgb got=%h required=%h", g, e);
        end
        scroll_row = 5'd0;
        vs_pulse();
    endtask

    task automatic test_out_area();
        logic [25:0] g, e;
        bit v;
        logic [25:0] a, b;
        a = {3'b000, 10'd640, 10'd0, 3'b001};
        b = {3'b111, 10'd640, 10'd0, 3'b100};
        step(a, g, e, v);
        n_tests++;
        if (mem_if.vram_addr !== 12'd0) begin
            n_fail++;
            $display("FAIL area_addr got=%0d required=0", mem_if.vram_addr);
        end
        for (int i = 0; i < 4; i++) step(b, g, e, v);
        n_tests++;
        if (g !== e || g !== {BG, a[22:0]}) begin
            n_fail++;
            $display("FAIL area_bg got=%h required=%h", g, {BG, a[22:0]});
        end
        step(b, g, e, v);
        n_tests++;
        if (g !== e || g !== {3'b000, b[22:0]}) begin
            n_fail++;
            $display("FAIL area_inactive got=%h required=%h", g, {3'b000, b[22:0]});
        end
    endtask

    task automatic test_back_to_back();
        logic [25:0] g, e;
        bit v;
        logic [11:0] fa;
        for (int i = 0; i < 20; i++) begin
            if (i < 16) step({3'b000, 10'(i), 10'd0, 3'b001}, g, e, v);
            else        step({3'b000, 10'd0, 10'd0, 3'b000}, g, e, v);
            n_tests++;
            if (!v || g !== e) begin
                n_fail++;
                $display("FAIL b2b_out[%0d] got=%h required=%h", i, g, e);
            end
            if (i < 16) begin
                n_tests++;
                if (mem_if.vram_addr !== ((i < 8) ? 12'd0 : 12'd1)) begin
                    n_fail++;
                    $display("FAIL b2b_vram[%0d] got=%0d required=%0d", i, mem_if.vram_addr, (i < 8) ? 0 : 1);
                end
            end
            if (i >= 2 && i < 18) begin
                fa = ((i - 2) < 8) ? 12'h200 : 12'h410;
                n_tests++;
                if (mem_if.font_addr !== fa) begin
                    n_fail++;
                    $display("FAIL b2b_font[%0d] got=%h required=%h", i, mem_if.font_addr, fa);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        RGBStr_i   = '0;
        scroll_row = '0;
        cursor_col = '0;
        cursor_row = '0;
        cursor_en  = 1'b0;
        fg_rgb     = FG;
        bg_rgb     = BG;
        for (int i = 0; i < 4096; i++) begin
            vram_m[i] = 8'h00;
            font_m[i] = 8'h00;
        end
        vram_m[0]     = 8'h20;
        vram_m[1]     = 8'h41;
        vram_m[80]    = 8'h42;
        vram_m[160]   = 8'h43;
        vram_m[162]   = 8'h41;
        vram_m[245]   = 8'h20;
        font_m[12'h413] = 8'h40;
        font_m[12'h410] = 8'hA5;
        font_m[12'h420] = 8'hFF;
        font_m[12'h430] = 8'h00;

        test_reset();
        test_cell_map();
        test_cursor_blink();
        test_scroll();
        test_out_area();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/text_console_pipe.md
Name: text_console_pipe

Overview:
Parametrised text-mode renderer stage on the 26-bit RGB pixel stream. It maps each pixel to a character cell, fetches the character code from video RAM, then fetches the glyph row from font ROM. It outputs the pixel coloured fg/bg, with hardware vertical scroll and a blinking block cursor. It sits between the sync generator stream and downstream overlay/VGA output stages.

Parameters:
GLYPH_W_LOG2, 3, log2 glyph width in pixels (8-px glyphs)
GLYPH_H_LOG2, 4, log2 glyph height in pixels (16-px glyphs)
COLS, 80, text columns
ROWS, 30, text rows
ADDR_W, 12, VRAM address width; must satisfy COLS*ROWS <= 2^ADDR_W
BLINK_FRAMES, 32, frames per cursor blink half-period

Ports:
px_clk  in  1  pixel clock; single clock domain
reset  in  1  synchronous, active-high reset
RGBStr_i  in  26  stream: [0] Active, [1] VS, [2] HS, [12:3] YC, [22:13] XC, [25:23] RGB
RGBStr_o  out  26  same format, delayed 4 cycles, RGB replaced
vram_addr  out  ADDR_W  character address to synchronous VRAM (1-cycle read)
vram_data  in  8  character code, valid the cycle after vram_addr
font_addr  out  8+GLYPH_H_LOG2  {char, glyph_row} to synchronous font ROM (1-cycle read)
font_data  in  2^GLYPH_W_LOG2  glyph row bits; MSB = leftmost pixel
scroll_row  in  $clog2(ROWS)  logical row 0 displays this physical row
cursor_col  in  $clog2(COLS)  cursor column (logical)
cursor_row  in  $clog2(ROWS)  cursor row (logical, pre-scroll)
cursor_en  in  1  cursor enable
fg_rgb  in  3  foreground colour
bg_rgb  in  3  background colour

Behaviour:
- Reset: RGBStr_o, vram_addr, font_addr = 0; all pipeline registers and side-band flags = 0; frame counter = 0; blink_on = 1; scroll_q = 0. Output is all-zero until the pipe refills (4 cycles after reset deassertion). Reset mid-frame behaves identically; there is no resync wait.
- Cell mapping: col = XC >> GLYPH_W_LOG2, row = YC >> GLYPH_H_LOG2, xoff = XC low GLYPH_W_LOG2 bits, yoff = YC low GLYPH_H_LOG2 bits.
- out_area = (col >= COLS) or (row >= ROWS).
- Scroll: phys = row + scroll_q; if phys >= ROWS then phys -= ROWS. There is exactly one conditional subtract.
- scroll_q latches scroll_row only on a VS rising edge (RGBStr_i VS 0->1, against a registered previous VS). A latched value >= ROWS is stored as 0.
- Stage timing (input sampled at edge k):
  - edge k: vram_addr <= out_area ? 0 : phys*COLS + col. Register xoff, yoff, out_area, cursor_hit and the stream.
  - edge k+2: font_addr <= {vram_data, yoff}. vram_data is captured after its 1-cycle RAM latency.
  - edge k+4: RGBStr_o updated; font_data is valid from edge k+3. Sync/position bits [22:0] equal the input bits from edge k exactly.
- cursor_hit = cursor_en & (col == cursor_col) & (row == cursor_row) & !out_area, using logical (pre-scroll) row.
- Pixel bit = font_data[2^GLYPH_W_LOG2-1-xoff] XOR (cursor_hit & blink_on).
- Output RGB:
  - !Active -> 000.
  - else out_area -> bg_rgb.
  - else pixel bit ? fg_rgb : bg_rgb.
  - fg/bg are sampled at the output stage.
- Blink: frame counter increments on each VS rising edge. On reaching BLINK_FRAMES-1 it wraps to 0 and blink_on toggles. A VS edge coincident with reset is ignored.
- The module does not stall: one pixel in, one pixel out, every cycle.
- Arithmetic: the phys*COLS+col product is sized to ADDR_W; there is no overflow for legal parameters.

Test Plan:
- Reset held 3 cycles then released, Active=1 stream -> RGBStr_o=0 for cycles 1-4 after release; cycle 5 reflects the first post-reset pixel.
- XC=17, YC=35, scroll 0 -> vram_addr=162 (row 2 col 2). Return vram_data=0x41 -> font_addr=0x413. font_data=8'h40 -> xoff=1 pixel = fg_rgb; RGBStr_o[22:0] equals the input 4 cycles earlier.
- scroll_row=29 applied, then VS rising edge; pixel at row 2 col 0 -> phys=1, vram_addr=80. scroll_row=31 latched -> behaves as 0 (row 2 -> addr 160).
- XC=640 (col 80) with Active=1 -> vram_addr=0, RGB=bg_rgb. Same pixel with Active=0 -> RGB=000, sync bits passed unchanged.
- cursor_en=1 at col 5 row 3, glyph bit 0 -> pixel shows fg. After 32 VS rising edges it shows bg. After 32 more it shows fg again. cursor_en=0 -> always glyph-only.
- Back-to-back pixels XC=0..15 on row 0, with vram_data 0x20/0x41 alternating per cell -> font_addr switches exactly at the 8-pixel boundary, delayed 2 cycles; no bubbles.
